// File: rtl/mcpu_soc_i2c_pkg.sv
// Shared definitions for the I2C command sequencer: peripheral register map,
// DR command field positions and the sequencer state encoding.
package mcpu_soc_i2c_pkg;

    localparam int CR_DRE = 2;
    localparam int CR_TXC = 1;
    localparam int CR_RXC = 0;

    localparam int DR_WE    = 10;
    localparam int DR_START = 9;
    localparam int DR_STOP  = 8;
    localparam int DR_DATA_MSB = 7;
    localparam int DR_DATA_LSB = 0;

    localparam logic ADDR_CR = 1'b0;
    localparam logic ADDR_DR = 1'b1;

    localparam int CMD_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_POLL  = 3'd2,
        ST_FETCH = 3'd3,
        ST_CLEAR = 3'd4
    } seq_state_e;

    // Writes wait for TXC, reads wait for RXC.
    function automatic logic cmd_done_bit(input logic is_wr, input logic [31:0] cr);
        return is_wr ? cr[CR_TXC] : cr[CR_RXC];
    endfunction

endpackage

// File: rtl/mcpu_soc_sync_fifo.sv
// Single-clock FIFO with synchronous flush; no push/pop bypass, so a pop
// never frees space for a push in the same cycle.
module mcpu_soc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == {(AW+1){1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_q[rd_ptr_q];

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {(AW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
            else           wr_ptr_d = wr_ptr_q;
            if (do_pop_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            else           rd_ptr_d = rd_ptr_q;
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mcpu_soc_i2c_seq.sv
// MMIO command sequencer in front of the SoC I2C peripheral.
// Optional POLL timeout and sticky err flag: define MCPU_SOC_I2C_SEQ_TIMEOUT_EN.
module mcpu_soc_i2c_seq
    import mcpu_soc_i2c_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic              clkrst_core_clk,
    input  logic              clkrst_core_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [7:0]        rx_data,
    output logic              busy,
    output logic              err,
    input  logic              err_clr,
    output logic              i2c_addr,
    output logic [31:0]       i2c_data_in,
    output logic [3:0]        i2c_write_en,
    input  logic [31:0]       i2c_data_out
);

    seq_state_e        state_q, state_d;
    logic              is_wr_q, is_wr_d;
    logic              addr_q, addr_d;
    logic [3:0]        we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CMD_W-1:0]  cmd_head_s;
    logic              cmd_full_s, cmd_empty_s, cmd_pop_s, cmd_flush_s;
    logic              rx_full_s, rx_empty_s, rx_push_s;
    logic              tmo_hit_s, tmo_set_s;
    logic [23:0]       unused_rd_hi_s;

    mcpu_soc_sync_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_cmd_fifo (
        .clk(clkrst_core_clk), .rst(clkrst_core_rst), .flush(cmd_flush_s),
        .push(cmd_valid), .push_data(cmd_data), .pop(cmd_pop_s),
        .head(cmd_head_s), .full(cmd_full_s), .empty(cmd_empty_s)
    );

    mcpu_soc_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clkrst_core_clk), .rst(clkrst_core_rst), .flush(1'b0),
        .push(rx_push_s), .push_data(i2c_data_out[DR_DATA_MSB:DR_DATA_LSB]), .pop(rx_ready),
        .head(rx_data), .full(rx_full_s), .empty(rx_empty_s)
    );

    assign cmd_ready      = !cmd_full_s;
    assign rx_valid       = !rx_empty_s;
    assign busy           = (state_q != ST_IDLE) || !cmd_empty_s;
    assign cmd_flush_s    = tmo_set_s;
    assign unused_rd_hi_s = i2c_data_out[31:8];
    assign i2c_addr       = addr_q;
    assign i2c_write_en   = we_q;
    assign i2c_data_in    = wdata_q;

    // Sequencer next state; bus outputs are computed one state ahead so they are registered.
    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        cmd_pop_s = 1'b0;
        rx_push_s = 1'b0;
        tmo_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!cmd_empty_s) begin
                    cmd_pop_s = 1'b1;
                    is_wr_d   = cmd_head_s[DR_WE];
                    state_d   = ST_ISSUE;
                    addr_d    = ADDR_DR;
                    we_d      = 4'h3;
                    wdata_d   = {21'h0, cmd_head_s};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_POLL;
                addr_d  = ADDR_CR;
                we_d    = 4'h0;
                wdata_d = 32'h0;
            end
            ST_POLL: begin
                if (cmd_done_bit(is_wr_q, i2c_data_out)) begin
                    if (is_wr_q) begin
                        state_d = ST_CLEAR;
                        addr_d  = ADDR_CR;
                        we_d    = 4'h1;
                        wdata_d = 32'h3;
                    end else begin
                        state_d = ST_FETCH;
                        addr_d  = ADDR_DR;
                    end
                end else if (tmo_hit_s) begin
                    tmo_set_s = 1'b1;
                    state_d   = ST_CLEAR;
                    addr_d    = ADDR_CR;
                    we_d      = 4'h1;
                    wdata_d   = 32'h3;
                end else begin
                    state_d = ST_POLL;
                end
            end
            ST_FETCH: begin
                // Back-pressure: hold here with RXC still set until the RX FIFO has room.
                if (!rx_full_s) begin
                    rx_push_s = 1'b1;
                    state_d   = ST_CLEAR;
                    addr_d    = ADDR_CR;
                    we_d      = 4'h1;
                    wdata_d   = 32'h3;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
                addr_d  = ADDR_CR;
                we_d    = 4'h0;
                wdata_d = 32'h0;
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = ADDR_CR;
                we_d    = 4'h0;
                wdata_d = 32'h0;
            end
        endcase
    end

    // Sequencer state and registered bus outputs.
    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            state_q <= ST_IDLE;
            is_wr_q <= 1'b0;
            addr_q  <= ADDR_CR;
            we_q    <= 4'h0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef MCPU_SOC_I2C_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d;

    assign tmo_hit_s = (tmo_cnt_q == TMO_LAST);
    assign err       = err_q;

    // POLL cycle counter (zero outside POLL) and sticky error; a timeout beats err_clr.
    always_comb begin
        if (state_q == ST_POLL) tmo_cnt_d = tmo_cnt_q + TW'(1);
        else                    tmo_cnt_d = {TW{1'b0}};
        if (tmo_set_s)          err_d = 1'b1;
        else if (err_clr)       err_d = 1'b0;
        else                    err_d = err_q;
    end

    // Timeout counter and error flag registers.
    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            tmo_cnt_q <= {TW{1'b0}};
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end
`else
    localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
    logic unused_err_clr_s;

    assign unused_err_clr_s = err_clr;
    assign tmo_hit_s        = 1'b0;
    assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_mcpu_soc_i2c_seq.sv
// Directed bench for mcpu_soc_i2c_seq against a small behavioural I2C peripheral
// stand-in (CR/DR registers, programmable completion latency, stall control).
module tb_mcpu_soc_i2c_seq;

    localparam int DEPTH = 8;
    localparam int TMO   = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [10:0] cmd_data = 11'h0;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data;
    logic        busy;
    logic        err;
    logic        err_clr = 1'b0;
    logic        i2c_addr;
    logic [31:0] i2c_data_in;
    logic [3:0]  i2c_write_en;
    logic [31:0] i2c_data_out;

    int total = 0;
    int bad   = 0;

    mcpu_soc_i2c_seq #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clkrst_core_clk(clk), .clkrst_core_rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .busy(busy), .err(err), .err_clr(err_clr),
        .i2c_addr(i2c_addr), .i2c_data_in(i2c_data_in),
        .i2c_write_en(i2c_write_en), .i2c_data_out(i2c_data_out)
    );

    always #5 clk = ~clk;

    // Peripheral stand-in: every MMIO write is logged as {addr, we, data}.
    logic        txc, rxc, pend, pend_rd;
    logic [7:0]  dr_rx, rd_idx, sda_byte;
    int          cnt;
    int          lat = 2;
    logic        stall = 1'b0;
    logic [36:0] wr_log [$];

    assign i2c_data_out = i2c_addr ? {24'h0, dr_rx} : {29'h0, ~pend, txc, rxc};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            txc <= 1'b0; rxc <= 1'b0; pend <= 1'b0; pend_rd <= 1'b0;
            cnt <= 0; dr_rx <= 8'h0; rd_idx <= 8'h0; sda_byte <= 8'h0;
        end else if (i2c_write_en != 4'h0) begin
            wr_log.push_back({i2c_addr, i2c_write_en, i2c_data_in});
            if (i2c_addr) begin
                pend <= 1'b1; pend_rd <= ~i2c_data_in[10]; cnt <= lat;
                if (i2c_data_in[10]) sda_byte <= i2c_data_in[7:0];
            end else begin
                if (i2c_data_in[1]) txc <= 1'b0;
                if (i2c_data_in[0]) rxc <= 1'b0;
            end
        end else if (pend && !stall) begin
            if (cnt == 0) begin
                pend <= 1'b0;
                if (pend_rd) begin
                    rxc <= 1'b1; dr_rx <= 8'h3C + 8'h11 * rd_idx; rd_idx <= rd_idx + 8'h1;
                end else begin
                    txc <= 1'b1;
                end
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    // Offer one command from a negedge; returns on the negedge after it is accepted.
    task automatic push_cmd(input logic [10:0] c, output int ok);
        ok = 0; cmd_valid = 1'b1; cmd_data = c;
        for (int g = 0; g < 300 && ok == 0; g++) begin
            if (cmd_ready) ok = 1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int ok);
        ok = 0;
        for (int g = 0; g < limit && ok == 0; g++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({i2c_addr, i2c_write_en, i2c_data_in} !== 37'h0) begin
            bad++; $display("FAIL reset_bus: got %h want 0", {i2c_addr, i2c_write_en, i2c_data_in});
        end
        total++;
        if ({rx_valid, busy, err, cmd_ready} !== 4'b0001) begin
            bad++; $display("FAIL reset_flags: got %b want 0001", {rx_valid, busy, err, cmd_ready});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({rx_valid, busy, err, cmd_ready} !== 4'b0001) begin
            bad++; $display("FAIL post_reset_flags: got %b want 0001", {rx_valid, busy, err, cmd_ready});
        end
    endtask

    task automatic test_write();
        int ok, base;
        base = wr_log.size(); lat = 3;
        push_cmd(11'h5A5, ok);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b want 1", busy); end
        @(negedge clk);
        total++;
        if ({i2c_addr, i2c_write_en, i2c_data_in} !== {1'b1, 4'h3, 32'h5A5}) begin
            bad++; $display("FAIL wr_issue: got %h want %h", {i2c_addr, i2c_write_en, i2c_data_in}, {1'b1, 4'h3, 32'h5A5});
        end
        @(negedge clk);
        total++;
        if ({i2c_addr, i2c_write_en} !== 5'h00) begin
            bad++; $display("FAIL wr_poll: got %h want 00", {i2c_addr, i2c_write_en});
        end
        wait_idle(60, ok);
        total++;
        if (ok != 1) begin bad++; $display("FAIL wr_idle: busy stuck, got 1 want 0"); end
        total++;
        if (wr_log.size() != base + 2) begin
            bad++; $display("FAIL wr_log_len: got %0d want %0d", wr_log.size() - base, 2);
        end else begin
            total++;
            if (wr_log[base] !== {1'b1, 4'h3, 32'h5A5} || wr_log[base+1] !== {1'b0, 4'h1, 32'h3}) begin
                bad++; $display("FAIL wr_log: got %h %h want %h %h", wr_log[base], wr_log[base+1], {1'b1, 4'h3, 32'h5A5}, {1'b0, 4'h1, 32'h3});
            end
        end
        total++;
        if ({sda_byte, txc} !== {8'hA5, 1'b0}) begin
            bad++; $display("FAIL wr_sda_txc: got %h %b want a5 0", sda_byte, txc);
        end
    endtask

    task automatic test_read();
        int ok, base;
        base = wr_log.size(); lat = 2;
        push_cmd(11'h100, ok);
        wait_idle(60, ok);
        total++;
        if (ok != 1) begin bad++; $display("FAIL rd_idle: busy stuck, got 1 want 0"); end
        total++;
        if ({rx_valid, rx_data} !== {1'b1, 8'h3C}) begin
            bad++; $display("FAIL rd_data: got %b %h want 1 3c", rx_valid, rx_data);
        end
        total++;
        if (rxc !== 1'b0) begin bad++; $display("FAIL rd_rxc: got %b want 0", rxc); end
        total++;
        if (wr_log.size() < base + 1 || wr_log[base] !== {1'b1, 4'h3, 32'h100}) begin
            bad++; $display("FAIL rd_dr_write: got %0d entries want first %h", wr_log.size() - base, {1'b1, 4'h3, 32'h100});
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        total++;
        if (rx_valid !== 1'b0) begin bad++; $display("FAIL rd_pop: rx_valid got %b want 0", rx_valid); end
    endtask

    task automatic test_back_to_back();
        int ok, base;
        logic [36:0] exp_e;
        base = wr_log.size(); lat = 6;
        for (int i = 0; i <= DEPTH; i++) begin
            push_cmd({3'b100, 8'hC0 + 8'(i)}, ok);
            if (ok != 1) begin total++; bad++; $display("FAIL b2b_push: cmd %0d not accepted", i); end
        end
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_full: cmd_ready got %b want 0", cmd_ready); end
        wait_idle(2000, ok);
        total++;
        if (ok != 1) begin bad++; $display("FAIL b2b_idle: busy stuck, got 1 want 0"); end
        total++;
        if (wr_log.size() != base + 2 * (DEPTH + 1)) begin
            bad++; $display("FAIL b2b_log_len: got %0d want %0d", wr_log.size() - base, 2 * (DEPTH + 1));
        end else begin
            for (int i = 0; i <= DEPTH; i++) begin
                exp_e = {1'b1, 4'h3, 32'h4C0 + 32'(i)};
                total++;
                if (wr_log[base + 2*i] !== exp_e || wr_log[base + 2*i + 1] !== {1'b0, 4'h1, 32'h3}) begin
                    bad++; $display("FAIL b2b_order[%0d]: got %h %h want %h %h", i, wr_log[base + 2*i], wr_log[base + 2*i + 1], exp_e, {1'b0, 4'h1, 32'h3});
                end
            end
        end
    endtask

    task automatic test_rx_full();
        int ok;
        logic [7:0] exp_rx [9];
        exp_rx = '{8'h4D, 8'h5E, 8'h6F, 8'h80, 8'h91, 8'hA2, 8'hB3, 8'hC4, 8'hD5};
        lat = 2;
        for (int i = 0; i <= DEPTH; i++) push_cmd(11'h000, ok);
        repeat (200) @(negedge clk);
        total++;
        if ({rx_valid, busy, i2c_addr, rxc, cmd_ready} !== 5'b11111) begin
            bad++; $display("FAIL rxf_hold: got %b want 11111", {rx_valid, busy, i2c_addr, rxc, cmd_ready});
        end
        total++;
        if (rx_data !== exp_rx[0]) begin bad++; $display("FAIL rxf_head: got %h want %h", rx_data, exp_rx[0]); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        wait_idle(60, ok);
        total++;
        if (ok != 1 || rxc !== 1'b0) begin bad++; $display("FAIL rxf_resume: idle %0d rxc %b want 1 0", ok, rxc); end
        for (int i = 1; i <= DEPTH; i++) begin
            total++;
            if ({rx_valid, rx_data} !== {1'b1, exp_rx[i]}) begin
                bad++; $display("FAIL rxf_data[%0d]: got %b %h want 1 %h", i, rx_valid, rx_data, exp_rx[i]);
            end
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
        total++;
        if (rx_valid !== 1'b0) begin bad++; $display("FAIL rxf_empty: rx_valid got %b want 0", rx_valid); end
    endtask

    task automatic test_timeout();
        int ok, base;
        base = wr_log.size(); stall = 1'b1;
`ifdef MCPU_SOC_I2C_SEQ_TIMEOUT_EN
        push_cmd(11'h411, ok);
        push_cmd(11'h422, ok);
        push_cmd(11'h433, ok);
        ok = 0;
        for (int g = 0; g < 300 && ok == 0; g++) begin
            @(negedge clk);
            if (err) ok = 1;
        end
        total++;
        if (ok != 1) begin bad++; $display("FAIL tmo_err: err got 0 want 1"); end
        wait_idle(20, ok);
        total++;
        if ({ok[0], cmd_ready, err} !== 3'b111) begin
            bad++; $display("FAIL tmo_flush: idle/ready/err got %b want 111", {ok[0], cmd_ready, err});
        end
        total++;
        if (wr_log.size() != base + 2 || wr_log[wr_log.size() - 1] !== {1'b0, 4'h1, 32'h3}) begin
            bad++; $display("FAIL tmo_log: got %0d entries want 2 ending in clear", wr_log.size() - base);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL tmo_clr: err got %b want 0", err); end
`else
        push_cmd(11'h411, ok);
        repeat (100) @(negedge clk);
        total++;
        if ({busy, err} !== 2'b10) begin bad++; $display("FAIL notmo_wait: busy/err got %b want 10", {busy, err}); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++;
        if (err !== 1'b0 || wr_log.size() != base + 1) begin
            bad++; $display("FAIL notmo_err: err %b log %0d want 0 1", err, wr_log.size() - base);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int ok, base;
        stall = 1'b1;
        push_cmd(11'h4FF, ok);
        push_cmd(11'h4EE, ok);
        repeat (4) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rstm_pre: busy got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({i2c_addr, i2c_write_en, i2c_data_in, rx_valid, busy, err, cmd_ready} !== {37'h0, 4'b0001}) begin
            bad++; $display("FAIL rstm_outputs: got %h want %h", {i2c_addr, i2c_write_en, i2c_data_in, rx_valid, busy, err, cmd_ready}, {37'h0, 4'b0001});
        end
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; lat = 1;
        base = wr_log.size();
        push_cmd(11'h5C3, ok);
        wait_idle(60, ok);
        total++;
        if (ok != 1) begin bad++; $display("FAIL rstm_idle: busy stuck, got 1 want 0"); end
        total++;
        if (wr_log.size() != base + 2) begin
            bad++; $display("FAIL rstm_log_len: got %0d want 2", wr_log.size() - base);
        end else if (wr_log[base] !== {1'b1, 4'h3, 32'h5C3} || wr_log[base+1] !== {1'b0, 4'h1, 32'h3}) begin
            bad++; $display("FAIL rstm_log: got %h %h want %h %h", wr_log[base], wr_log[base+1], {1'b1, 4'h3, 32'h5C3}, {1'b0, 4'h1, 32'h3});
        end
        total++;
        if ({sda_byte, txc} !== {8'hC3, 1'b0}) begin
            bad++; $display("FAIL rstm_sda: got %h %b want c3 0", sda_byte, txc);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_rx_full();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
